// File: rtl/gcd_pkg.sv
// Shared definitions for the gcd arbiter slice.
//   - state_t      : controller states (IDLE, LOAD, RUN, RESP)
//   - DEFAULT_WIDTH: default operand/result width
//   - clog2()      : index width helper, never returns less than 1 so a
//                    width derived from it is always a legal vector width
package gcd_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >>> 1;
        end
        if (result < 1) begin
            result = 1;
        end else begin
            result = result;
        end
        return result;
    endfunction

endpackage

// File: rtl/gcd_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector, one bit per requester
//   ptr       : highest-priority index for this decision
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : index of the granted requester
//   grant_any : at least one request present
module rr_arbiter
    import gcd_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    logic [NREQ-1:0] rot_s;
    logic [IDW:0]    off_s;
    logic [IDW:0]    sum_s;

    // Rotate so ptr sits at bit 0, pick the lowest set bit, then rotate the
    // offset back into an absolute index (modulo NREQ, which need not be 2^n).
    always_comb begin
        rot_s = NREQ'({req, req} >> ptr);
        off_s = {(IDW+1){1'b0}};
        for (int i = NREQ - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? (IDW+1)'(i) : off_s;
        end
        sum_s     = {1'b0, ptr} + off_s;
        grant_idx = (sum_s >= (IDW+1)'(NREQ)) ? IDW'(sum_s - (IDW+1)'(NREQ))
                                                : IDW'(sum_s);
        grant_any = |req;
        grant     = grant_any ? (NREQ'(1) << grant_idx) : {NREQ{1'b0}};
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one gcd core among NREQ requesters.
//   req_*       : per-requester valid / ready / operands (packed i*WIDTH)
//   rsp_*       : single response channel (id, result, timeout flag)
//   core_*      : connection to the gcd core (operands, reset, result, DONE)
// Jobs with a zero operand bypass the core; everything else is loaded while
// core_reset is held high, computed with core_reset low, and aborted with
// rsp_err after TIMEOUT cycles without DONE.
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter  int NREQ        = 4,
    parameter  int WIDTH       = DEFAULT_WIDTH,
    parameter  int LOAD_CYCLES = 2,
    parameter  int TIMEOUT     = 4096,
    localparam int IDW         = clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_gcd,
    output logic                  rsp_err,
    output logic [WIDTH-1:0]      core_num1,
    output logic [WIDTH-1:0]      core_num2,
    output logic                  core_reset,
    input  logic [WIDTH-1:0]      core_gcd_out,
    input  logic                  core_done
);

    localparam int LCW = clog2(LOAD_CYCLES + 1);
    localparam int TCW = clog2(TIMEOUT);

    state_t            state_r, state_n;
    logic [IDW-1:0]    ptr_r, ptr_n;
    logic [WIDTH-1:0]  a_r, b_r;
    logic [LCW-1:0]    load_cnt_r;
    logic [TCW-1:0]    run_cnt_r;
    logic              rsp_valid_r, rsp_err_r, core_reset_r;
    logic [IDW-1:0]    rsp_id_r;
    logic [WIDTH-1:0]  rsp_gcd_r;

    logic [NREQ-1:0]   grant_s;
    logic [IDW-1:0]    grant_idx_s;
    logic              grant_any_s;
    logic [WIDTH-1:0]  sel_a_s, sel_b_s;
    logic              accept_s, bypass_s, done_s, timeout_s;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req       (req_valid),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    assign sel_a_s = req_a[grant_idx_s*WIDTH +: WIDTH];
    assign sel_b_s = req_b[grant_idx_s*WIDTH +: WIDTH];
    assign ptr_n   = (grant_idx_s == IDW'(NREQ - 1)) ? {IDW{1'b0}}
                                                     : grant_idx_s + IDW'(1);

    // Accept is combinational in IDLE only; masked during reset because the
    // grant would be discarded by that same edge.
    assign req_ready = (state_r == IDLE && !reset) ? grant_s : {NREQ{1'b0}};

    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_gcd    = rsp_gcd_r;
    assign rsp_err    = rsp_err_r;
    assign core_num1  = a_r;
    assign core_num2  = b_r;
    assign core_reset = core_reset_r;

    // Next-state logic and single-cycle event strobes for the datapath.
    always_comb begin
        state_n   = state_r;
        accept_s  = 1'b0;
        bypass_s  = 1'b0;
        done_s    = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_any_s) begin
                    accept_s = 1'b1;
                    if (sel_a_s == {WIDTH{1'b0}} || sel_b_s == {WIDTH{1'b0}}) begin
                        bypass_s = 1'b1;
                        state_n  = RESP;
                    end else begin
                        state_n  = LOAD;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            LOAD: begin
                if (load_cnt_r == {LCW{1'b0}}) begin
                    state_n = RUN;
                end else begin
                    state_n = LOAD;
                end
            end
            RUN: begin
                // DONE has priority over a timeout in the same cycle.
                if (core_done) begin
                    done_s  = 1'b1;
                    state_n = RESP;
                end else if (run_cnt_r == TCW'(TIMEOUT - 1)) begin
                    timeout_s = 1'b1;
                    state_n   = RESP;
                end else begin
                    state_n = RUN;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end else begin
                    state_n = RESP;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Datapath registers: job latch, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r        <= {IDW{1'b0}};
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            load_cnt_r   <= {LCW{1'b0}};
            run_cnt_r    <= {TCW{1'b0}};
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= {IDW{1'b0}};
            rsp_gcd_r    <= {WIDTH{1'b0}};
            rsp_err_r    <= 1'b0;
            core_reset_r <= 1'b1;
        end else begin
            rsp_valid_r  <= (state_n == RESP);
            core_reset_r <= (state_n != RUN);

            if (accept_s) begin
                a_r        <= sel_a_s;
                b_r        <= sel_b_s;
                rsp_id_r   <= grant_idx_s;
                ptr_r      <= ptr_n;
                load_cnt_r <= LCW'(LOAD_CYCLES - 1);
            end else if (state_r == LOAD && load_cnt_r != {LCW{1'b0}}) begin
                load_cnt_r <= load_cnt_r - LCW'(1);
            end else begin
                load_cnt_r <= load_cnt_r;
            end

            // RUN cycle count starts at zero on the first RUN cycle and
            // never passes TIMEOUT-1 because RUN is left at that value.
            if (state_r == LOAD) begin
                run_cnt_r <= {TCW{1'b0}};
            end else if (state_r == RUN && run_cnt_r != TCW'(TIMEOUT - 1)) begin
                run_cnt_r <= run_cnt_r + TCW'(1);
            end else begin
                run_cnt_r <= run_cnt_r;
            end

            // gcd(x,0) = x and gcd(0,0) = 0, so a|b covers every bypass case.
            if (bypass_s) begin
                rsp_gcd_r <= sel_a_s | sel_b_s;
                rsp_err_r <= 1'b0;
            end else if (done_s) begin
                rsp_gcd_r <= core_gcd_out;
                rsp_err_r <= 1'b0;
            end else if (timeout_s) begin
                rsp_gcd_r <= {WIDTH{1'b0}};
                rsp_err_r <= 1'b1;
            end else begin
                rsp_gcd_r <= rsp_gcd_r;
                rsp_err_r <= rsp_err_r;
            end
        end
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a behavioural Euclid core that can be
// swapped for a stub (forced DONE / result) to exercise timeout handling.
module tb_gcd_arbiter;

    localparam int NREQ        = 4;
    localparam int WIDTH       = 32;
    localparam int LOAD_CYCLES = 2;
    localparam int TIMEOUT     = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic                  rsp_valid, rsp_ready, rsp_err;
    logic [1:0]            rsp_id;
    logic [WIDTH-1:0]      rsp_gcd, core_num1, core_num2, core_gcd_out;
    logic                  core_reset, core_done;

    logic [WIDTH-1:0] cx, cy, mgcd, stub_gcd;
    logic             mdone, stub_en, stub_done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gcd_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LOAD_CYCLES(LOAD_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_gcd(rsp_gcd), .rsp_err(rsp_err),
        .core_num1(core_num1), .core_num2(core_num2), .core_reset(core_reset),
        .core_gcd_out(core_gcd_out), .core_done(core_done)
    );

    // Behavioural gcd core: loads in reset, one Euclid step per cycle after.
    always_ff @(posedge clk) begin
        if (core_reset) begin
            cx <= core_num1; cy <= core_num2; mdone <= 1'b0; mgcd <= 32'd0;
        end else if (!mdone) begin
            if (cy == 32'd0) begin
                mdone <= 1'b1; mgcd <= cx;
            end else begin
                cx <= cy; cy <= cx % cy;
            end
        end
    end

    assign core_done    = stub_en ? stub_done : mdone;
    assign core_gcd_out = stub_en ? stub_gcd  : mgcd;

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    // Called at a negedge; returns at negedge+1 of the grant cycle.
    task automatic wait_grant(input int max_cyc, output logic [NREQ-1:0] g, output bit ok);
        ok = 1'b0; g = 4'b0000;
        for (int i = 0; i < max_cyc; i++) begin
            #1;
            if (req_ready !== 4'b0000) begin g = req_ready; ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_rsp(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (rsp_valid === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic drop_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rsp_ready = 1'b0; req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_op(i, 32'd12, 32'd8);
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        n_vec++; if (rsp_gcd !== 32'd0 || rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_data: got gcd=%0h err=%b want 0/0", rsp_gcd, rsp_err); end
        n_vec++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL reset_core_reset: got %b want 1", core_reset); end
        n_vec++; if (core_num1 !== 32'd0 || core_num2 !== 32'd0) begin n_err++; $display("FAIL reset_core_num: got %0h/%0h want 0/0", core_num1, core_num2); end
        req_valid = 4'b0000; reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_four();
        logic [WIDTH-1:0] ea[4] = '{32'd48, 32'd100, 32'd17, 32'd81};
        logic [WIDTH-1:0] eb[4] = '{32'd18, 32'd75, 32'd5, 32'd27};
        logic [WIDTH-1:0] eg[7] = '{32'd6, 32'd25, 32'd1, 32'd27, 32'd4, 32'd7, 32'd3};
        int               eid[7] = '{0, 1, 2, 3, 2, 3, 1};
        logic [NREQ-1:0]  g;
        bit               ok;
        for (int i = 0; i < 4; i++) set_op(i, ea[i], eb[i]);
        req_valid = 4'b1111;
        for (int k = 0; k < 7; k++) begin
            // Steps 4..6 check that the pointer, not the index order, decides.
            if (k == 4) begin set_op(2, 32'd12, 32'd8); req_valid = 4'b0100; end
            if (k == 5) begin set_op(1, 32'd9, 32'd3); set_op(3, 32'd21, 32'd14); req_valid = 4'b1010; end
            wait_grant(10, g, ok);
            n_vec++; if (!ok || g !== (4'b0001 << eid[k])) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", k, g, 4'b0001 << eid[k]); end
            @(negedge clk);
            req_valid = req_valid & ~g;
            wait_rsp(40, ok);
            n_vec++; if (!ok || rsp_id !== 2'(eid[k]) || rsp_gcd !== eg[k] || rsp_err !== 1'b0) begin
                n_err++; $display("FAIL rr_rsp%0d: got id=%0d gcd=%0d err=%b valid=%b want id=%0d gcd=%0d err=0", k, rsp_id, rsp_gcd, rsp_err, ok, eid[k], eg[k]);
            end
            drop_rsp();
        end
    endtask

    task automatic test_single();
        logic [NREQ-1:0] g;
        bit              ok;
        set_op(0, 32'd161, 32'd14);
        req_valid = 4'b0001;
        wait_grant(10, g, ok);
        n_vec++; if (!ok || g !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b want 0001", g); end
        @(negedge clk); req_valid = 4'b0000; #1;
        n_vec++; if (core_reset !== 1'b1 || core_num1 !== 32'd161 || core_num2 !== 32'd14) begin
            n_err++; $display("FAIL single_load1: got rst=%b n1=%0d n2=%0d want 1/161/14", core_reset, core_num1, core_num2);
        end
        @(negedge clk); #1;
        n_vec++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL single_load2: got core_reset=%b want 1", core_reset); end
        @(negedge clk); #1;
        n_vec++; if (core_reset !== 1'b0) begin n_err++; $display("FAIL single_run: got core_reset=%b want 0", core_reset); end
        wait_rsp(40, ok);
        n_vec++; if (!ok || rsp_id !== 2'd0 || rsp_gcd !== 32'd7 || rsp_err !== 1'b0) begin
            n_err++; $display("FAIL single_rsp: got id=%0d gcd=%0d err=%b valid=%b want 0/7/0", rsp_id, rsp_gcd, rsp_err, ok);
        end
        drop_rsp(); #1;
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp_drop: got %b want 0", rsp_valid); end
    endtask

    task automatic test_bypass();
        logic [NREQ-1:0] g;
        bit              ok;
        logic [WIDTH-1:0] want[2] = '{32'd25, 32'd0};
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin set_op(1, 32'd0, 32'd25); req_valid = 4'b0010; end
            else        begin set_op(2, 32'd0, 32'd0);  req_valid = 4'b0100; end
            wait_grant(10, g, ok);
            n_vec++; if (!ok || g !== (4'b0010 << k)) begin n_err++; $display("FAIL bypass_grant%0d: got %b want %b", k, g, 4'b0010 << k); end
            @(negedge clk); req_valid = 4'b0000; #1;
            n_vec++; if (rsp_valid !== 1'b1 || rsp_gcd !== want[k] || rsp_err !== 1'b0 || rsp_id !== 2'(k + 1)) begin
                n_err++; $display("FAIL bypass_rsp%0d: got v=%b gcd=%0d err=%b id=%0d want 1/%0d/0/%0d", k, rsp_valid, rsp_gcd, rsp_err, rsp_id, want[k], k + 1);
            end
            n_vec++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL bypass_core_reset%0d: got %b want 1", k, core_reset); end
            drop_rsp(); #1;
            n_vec++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL bypass_core_reset_after%0d: got %b want 1", k, core_reset); end
        end
    endtask

    task automatic test_backpressure();
        logic [NREQ-1:0] g;
        bit              ok;
        set_op(3, 32'd161, 32'd14);
        set_op(0, 32'd50, 32'd20);
        req_valid = 4'b1000;
        wait_grant(10, g, ok);
        n_vec++; if (!ok || g !== 4'b1000) begin n_err++; $display("FAIL bp_grant: got %b want 1000", g); end
        @(negedge clk); req_valid = 4'b0001;
        wait_rsp(40, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL bp_rsp_timeout: got no rsp_valid want rsp_valid"); end
        for (int c = 0; c < 6; c++) begin
            #1;
            n_vec++; if (rsp_valid !== 1'b1 || rsp_gcd !== 32'd7 || rsp_id !== 2'd3 || req_ready !== 4'b0000) begin
                n_err++; $display("FAIL bp_hold%0d: got v=%b gcd=%0d id=%0d rdy=%b want 1/7/3/0000", c, rsp_valid, rsp_gcd, rsp_id, req_ready);
            end
            if (c == 5) rsp_ready = 1'b1;
            @(negedge clk);
        end
        rsp_ready = 1'b0; #1;
        n_vec++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin
            n_err++; $display("FAIL bp_release: got v=%b rdy=%b want 0/0001", rsp_valid, req_ready);
        end
        @(negedge clk); req_valid = 4'b0000;
        wait_rsp(40, ok);
        n_vec++; if (!ok || rsp_id !== 2'd0 || rsp_gcd !== 32'd10) begin
            n_err++; $display("FAIL bp_next_rsp: got id=%0d gcd=%0d valid=%b want 0/10", rsp_id, rsp_gcd, ok);
        end
        drop_rsp();
    endtask

    task automatic test_timeout();
        logic [NREQ-1:0] g;
        bit              ok;
        int              early;
        int              rst_bad;
        stub_en = 1'b1; stub_done = 1'b0;
        set_op(1, 32'd9, 32'd6);
        for (int r = 0; r < 2; r++) begin
            stub_gcd = (r == 0) ? 32'hAA : 32'h55;
            req_valid = 4'b0010;
            wait_grant(10, g, ok);
            n_vec++; if (!ok || g !== 4'b0010) begin n_err++; $display("FAIL to_grant%0d: got %b want 0010", r, g); end
            early = 0; rst_bad = 0;
            for (int c = 1; c <= 18; c++) begin
                @(negedge clk);
                if (c == 1) req_valid = 4'b0000;
                // A DONE seen during LOAD must be ignored.
                if (c == 1) stub_done = 1'b1;
                if (c == 3) stub_done = 1'b0;
                if (c == 18 && r == 1) stub_done = 1'b1;
                #1;
                if (rsp_valid !== 1'b0) early++;
                if (c >= 3 && core_reset !== 1'b0) rst_bad++;
            end
            n_vec++; if (early != 0) begin n_err++; $display("FAIL to_early%0d: got %0d cycles with rsp_valid want 0", r, early); end
            n_vec++; if (rst_bad != 0) begin n_err++; $display("FAIL to_run_reset%0d: got %0d RUN cycles with core_reset high want 0", r, rst_bad); end
            @(negedge clk); #1;
            n_vec++; if (rsp_valid !== 1'b1 || rsp_err !== (r == 0) || rsp_gcd !== ((r == 0) ? 32'd0 : 32'h55) || rsp_id !== 2'd1) begin
                n_err++; $display("FAIL to_rsp%0d: got v=%b err=%b gcd=%0h id=%0d want 1/%0d/%0h/1", r, rsp_valid, rsp_err, rsp_gcd, rsp_id, r == 0, (r == 0) ? 32'd0 : 32'h55);
            end
            stub_done = 1'b0;
            drop_rsp();
        end
        stub_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0] g;
        bit              ok;
        set_op(2, 32'd161, 32'd14);
        req_valid = 4'b0100;
        wait_grant(10, g, ok);
        n_vec++; if (!ok || g !== 4'b0100) begin n_err++; $display("FAIL rm_grant: got %b want 0100", g); end
        @(negedge clk); req_valid = 4'b0000;
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (core_reset !== 1'b0) begin n_err++; $display("FAIL rm_in_run: got core_reset=%b want 0", core_reset); end
        reset = 1'b1;
        @(negedge clk); #1;
        n_vec++; if (rsp_valid !== 1'b0 || core_reset !== 1'b1 || core_num1 !== 32'd0 || rsp_gcd !== 32'd0 || rsp_id !== 2'd0) begin
            n_err++; $display("FAIL rm_after_reset: got v=%b crst=%b n1=%0d gcd=%0h id=%0d want 0/1/0/0/0", rsp_valid, core_reset, core_num1, rsp_gcd, rsp_id);
        end
        reset = 1'b0;
        set_op(1, 32'd161, 32'd14);
        set_op(3, 32'd5, 32'd10);
        @(negedge clk);
        req_valid = 4'b1010;
        wait_grant(10, g, ok);
        n_vec++; if (!ok || g !== 4'b0010) begin n_err++; $display("FAIL rm_ptr_grant: got %b want 0010", g); end
        @(negedge clk); req_valid = 4'b0000;
        wait_rsp(40, ok);
        n_vec++; if (!ok || rsp_id !== 2'd1 || rsp_gcd !== 32'd7 || rsp_err !== 1'b0) begin
            n_err++; $display("FAIL rm_fresh_rsp: got id=%0d gcd=%0d err=%b valid=%b want 1/7/0", rsp_id, rsp_gcd, rsp_err, ok);
        end
        drop_rsp();
    endtask

    initial begin
        reset = 1'b1; req_valid = 4'b0000; rsp_ready = 1'b0;
        req_a = '0; req_b = '0;
        stub_en = 1'b0; stub_done = 1'b0; stub_gcd = 32'd0;
        @(negedge clk);
        test_reset();
        test_all_four();
        test_single();
        test_bypass();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
